// File: rtl/ram_stream_loader.sv
// ---------------------------------------------------------------------------
// ram_stream_loader
//
// Purpose:
//   Bridges a word stream to and from the two kernel SinglePortRams (imem and
//   dmem). Both RAMs form one unified word space: indices 0..2^IMEM_AW-1 map
//   to imem, and the next 2^DMEM_AW indices map to dmem.
//     - Load mode (MODE=0): the S_* stream is written into the unified space.
//     - Unload mode (MODE=1): the unified space is read out onto the M_*
//       stream. A 2-entry skid buffer absorbs the 1-cycle RAM read latency
//       while M_READY is low.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   Defined   : CHECKSUM is a modulo-2^DATA_WIDTH sum of every word written
//               (load) or accepted on M (unload). It clears on an accepted
//               START and holds its value after DONE.
//   Undefined : CHECKSUM is tied to zero and no adder is built.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   START/MODE/START_IDX/LEN   command; sampled only in IDLE
//   BUSY, DONE, ERR   status (DONE is a 1-cycle pulse, ERR is sticky)
//   CHECKSUM          running word sum (see above)
//   S_VALID/S_READY/S_DATA/S_LAST   load stream (sink)
//   M_VALID/M_READY/M_DATA/M_LAST   unload stream (source)
//   imem_* / dmem_*   single-port RAM interfaces; q arrives 1 cycle after a
//                     read request
// ---------------------------------------------------------------------------
module ram_stream_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_AW    = 6,
    parameter int DMEM_AW    = 7
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  MODE,
    input  logic [7:0]            START_IDX,
    input  logic [15:0]           LEN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic [DATA_WIDTH-1:0] CHECKSUM,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [DATA_WIDTH-1:0] S_DATA,
    input  logic                  S_LAST,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_LAST,
    output logic [IMEM_AW-1:0]    imem_addr,
    output logic [DATA_WIDTH-1:0] imem_d,
    output logic                  imem_we,
    output logic                  imem_req,
    input  logic [DATA_WIDTH-1:0] imem_q,
    output logic [DMEM_AW-1:0]    dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_d,
    output logic                  dmem_we,
    output logic                  dmem_req,
    input  logic [DATA_WIDTH-1:0] dmem_q
);

    // Unified index must hold START_IDX + LEN (8-bit + 16-bit) without wrap.
    localparam int IDX_W      = 17;
    localparam int IMEM_WORDS = 1 << IMEM_AW;
    localparam int TOTAL      = IMEM_WORDS + (1 << DMEM_AW);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_UNLOAD = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [15:0]           r_cnt;
    logic [15:0]           r_len;
    logic [15:0]           r_issued;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_s_ready;

    // Skid buffer: entry 0 is the head presented on M_*.
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic                  r_last0;
    logic                  r_last1;
    logic [1:0]            r_occ;
    // A read issued last cycle whose data is on *_q this cycle.
    logic                  r_inflight;
    logic                  r_inflight_dmem;
    logic                  r_inflight_last;

    logic                  w_start_acc;
    logic [IDX_W-1:0]      w_end_idx;
    logic                  w_range_bad;
    logic                  w_ld_fire;
    logic                  w_rd_issue;
    logic                  w_issue_last;
    logic                  w_sel_dmem;
    logic [DMEM_AW-1:0]    w_dm_off;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [1:0]            w_occ_nxt;

    // Command decode, transfer qualifiers and skid-buffer bookkeeping.
    always_comb begin
        w_start_acc  = (r_state == ST_IDLE) && START;
        w_end_idx    = IDX_W'(START_IDX) + IDX_W'(LEN);
        w_range_bad  = (w_end_idx > IDX_W'(TOTAL));
        w_ld_fire    = (r_state == ST_LOAD) && r_s_ready && S_VALID;
        // Conservative credit: a same-cycle pop is not counted as free space.
        w_rd_issue   = (r_state == ST_UNLOAD) && (r_issued < r_len) &&
                       (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd2);
        w_issue_last = (r_issued == (r_len - 16'd1));
        w_sel_dmem   = (r_idx >= IDX_W'(IMEM_WORDS));
        w_dm_off     = DMEM_AW'(r_idx - IDX_W'(IMEM_WORDS));
        w_push       = r_inflight;
        w_pop        = (r_occ != 2'd0) && M_READY;
        if (r_inflight_dmem) begin
            w_push_data = dmem_q;
        end else begin
            w_push_data = imem_q;
        end
        case ({w_push, w_pop})
            2'b10:   w_occ_nxt = r_occ + 2'd1;
            2'b01:   w_occ_nxt = r_occ - 2'd1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // RAM port drive: only the RAM being accessed this cycle sees req, and
    // everything idles at zero otherwise so the external mux select stays
    // one-hot or empty.
    always_comb begin
        imem_addr = {IMEM_AW{1'b0}};
        imem_d    = {DATA_WIDTH{1'b0}};
        imem_we   = 1'b0;
        imem_req  = 1'b0;
        dmem_addr = {DMEM_AW{1'b0}};
        dmem_d    = {DATA_WIDTH{1'b0}};
        dmem_we   = 1'b0;
        dmem_req  = 1'b0;
        if (w_ld_fire || w_rd_issue) begin
            if (w_sel_dmem) begin
                dmem_req  = 1'b1;
                dmem_we   = w_ld_fire;
                dmem_addr = w_dm_off;
                dmem_d    = w_ld_fire ? S_DATA : {DATA_WIDTH{1'b0}};
            end else begin
                imem_req  = 1'b1;
                imem_we   = w_ld_fire;
                imem_addr = r_idx[IMEM_AW-1:0];
                imem_d    = w_ld_fire ? S_DATA : {DATA_WIDTH{1'b0}};
            end
        end else begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_idx     <= {IDX_W{1'b0}};
            r_cnt     <= 16'd0;
            r_len     <= 16'd0;
            r_issued  <= 16'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_s_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_err <= 1'b0;
                        if (w_range_bad) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else if (LEN == 16'd0) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_idx    <= IDX_W'(START_IDX);
                            r_cnt    <= LEN;
                            r_len    <= LEN;
                            r_issued <= 16'd0;
                            r_busy   <= 1'b1;
                            if (MODE) begin
                                r_state <= ST_UNLOAD;
                            end else begin
                                r_s_ready <= 1'b1;
                                r_state   <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_ld_fire) begin
                        r_idx <= r_idx + IDX_W'(1);
                        r_cnt <= r_cnt - 16'd1;
                        // Ends on S_LAST or on the final counted beat; the
                        // two disagreeing is an error either way.
                        if (S_LAST || (r_cnt == 16'd1)) begin
                            if (S_LAST != (r_cnt == 16'd1)) begin
                                r_err <= 1'b1;
                            end
                            r_s_ready <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= ST_FIN;
                        end
                    end
                end
                ST_UNLOAD: begin
                    if (w_rd_issue) begin
                        r_idx    <= r_idx + IDX_W'(1);
                        r_issued <= r_issued + 16'd1;
                        if (w_issue_last) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Finish on the pop that drains the last buffered word.
                    if ((w_occ_nxt == 2'd0) && !r_inflight) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_s_ready <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Read pipeline and 2-entry skid buffer for the unload stream.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_inflight      <= 1'b0;
            r_inflight_dmem <= 1'b0;
            r_inflight_last <= 1'b0;
            r_buf0          <= {DATA_WIDTH{1'b0}};
            r_buf1          <= {DATA_WIDTH{1'b0}};
            r_last0         <= 1'b0;
            r_last1         <= 1'b0;
            r_occ           <= 2'd0;
        end else begin
            r_inflight      <= w_rd_issue;
            r_inflight_dmem <= w_sel_dmem;
            r_inflight_last <= w_issue_last;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0  <= w_push_data;
                        r_last0 <= r_inflight_last;
                    end else begin
                        r_buf1  <= w_push_data;
                        r_last1 <= r_inflight_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0  <= r_buf1;
                    r_last0 <= r_last1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Pop and push together: occupancy is unchanged.
                    if (r_occ == 2'd1) begin
                        r_buf0  <= w_push_data;
                        r_last0 <= r_inflight_last;
                    end else begin
                        r_buf0  <= r_buf1;
                        r_last0 <= r_last1;
                        r_buf1  <= w_push_data;
                        r_last1 <= r_inflight_last;
                    end
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    // Running modulo sum of words written (load) or accepted on M (unload).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_checksum <= {DATA_WIDTH{1'b0}};
        end else if (w_start_acc) begin
            r_checksum <= {DATA_WIDTH{1'b0}};
        end else if (w_ld_fire) begin
            r_checksum <= r_checksum + S_DATA;
        end else if (w_pop) begin
            r_checksum <= r_checksum + r_buf0;
        end else begin
            r_checksum <= r_checksum;
        end
    end

    assign CHECKSUM = r_checksum;
`else
    assign CHECKSUM = {DATA_WIDTH{1'b0}};
`endif

    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign ERR     = r_err;
    assign S_READY = r_s_ready;
    assign M_VALID = (r_occ != 2'd0);
    assign M_DATA  = r_buf0;
    assign M_LAST  = r_last0 && (r_occ != 2'd0);

endmodule

// File: doc/ram_stream_loader.md
Name: ram_stream_loader

Overview:
- Sits between the AXI master's read/write data path and the two kernel SinglePortRams (imem 64 words, dmem 128 words) on the RAM-side mux port.
- Load mode: consumes a valid/ready word stream and writes it into a unified word space. Words at index 0..63 go to imem; index 64..191 go to dmem.
- Unload mode: reads the same unified space and emits a word stream for AXI write-back. A 2-entry skid buffer absorbs the 1-cycle RAM read latency under backpressure.

Parameters:
- DATA_WIDTH, 32, word width of streams and RAMs.
- IMEM_AW, 6, imem address width; imem occupies unified indices 0..2^IMEM_AW-1.
- DMEM_AW, 7, dmem address width; dmem follows imem in the unified space.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- START  in  1  1-cycle pulse; samples MODE, START_IDX, LEN. Ignored when BUSY=1.
- MODE  in  1  0 = load (stream to RAM), 1 = unload (RAM to stream).
- START_IDX  in  8  first unified word index.
- LEN  in  16  word count.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  1-cycle completion pulse.
- ERR  out  1  sticky error flag; cleared by the next accepted START.
- CHECKSUM  out  DATA_WIDTH  see Optional Feature.
- S_VALID, S_READY, S_DATA[DATA_WIDTH], S_LAST  in/out/in/in  load stream.
- M_VALID, M_READY, M_DATA[DATA_WIDTH], M_LAST  out/in/out/out  unload stream.
- imem_addr[IMEM_AW] out, imem_d[DATA_WIDTH] out, imem_we out, imem_req out, imem_q[DATA_WIDTH] in  imem port.
- dmem_addr[DMEM_AW] out, dmem_d[DATA_WIDTH] out, dmem_we out, dmem_req out, dmem_q[DATA_WIDTH] in  dmem port.

Behaviour:
- Clocking: single clock CLK; RST synchronous active-high.
- Reset values: state IDLE. BUSY, DONE, ERR, S_READY, M_VALID, M_LAST, all *_req and *_we = 0. Addresses, data, CHECKSUM = 0. Skid buffer empty.
- RAM port: *_req is high only in a cycle that actually accesses that RAM, and at most one RAM is requested per cycle. This keeps the external one-hot mux select legal. RAM read data appears on *_q one cycle after req with we=0.
- States: IDLE, LOAD, UNLOAD, FLUSH, FIN.
- IDLE + START:
  - If START_IDX+LEN > 2^IMEM_AW + 2^DMEM_AW (192 by default): set ERR, go to FIN.
  - Else if LEN = 0: go to FIN.
  - Else go to LOAD or UNLOAD per MODE. Load idx = START_IDX, cnt = LEN.
- LOAD:
  - S_READY=1.
  - On each handshake, write S_DATA to the RAM mapped by idx (same cycle, req=we=1), then idx+1, cnt-1.
  - S_LAST on the beat where cnt=1: normal end, go to FIN.
  - S_LAST on an earlier beat: write that beat, set ERR, go to FIN.
  - cnt reaches 0 without S_LAST: set ERR, go to FIN.
  - S_READY drops the cycle after the final beat.
- UNLOAD:
  - Issue a read (req=1, we=0) when issue count < LEN and (buffered + in-flight) < 2.
  - The captured *_q word is pushed into the skid buffer the cycle after issue.
  - M_VALID = buffer not empty; M_DATA/M_LAST come from the buffer head.
  - M_LAST marks the LEN-th word.
  - Pop on M_VALID & M_READY.
  - Move to FLUSH when all reads are issued; FLUSH waits for the buffer to empty.
  - Simultaneous push and pop with the buffer full is legal; occupancy stays 2.
  - M_VALID/M_DATA stay stable until accepted.
- FIN: DONE=1 for one cycle, BUSY=0, return to IDLE. START in FIN is ignored.
- Boundary: the imem to dmem crossing (idx 63 to 64) is seamless. dmem_addr = idx - 2^IMEM_AW, truncated to DMEM_AW bits.
- RST mid-operation: abort immediately, all outputs return to reset values, RAM contents are untouched.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: CHECKSUM clears on accepted START. It then accumulates a modulo-2^DATA_WIDTH sum of every word written (load) or accepted on M (unload), and holds its value after DONE.
- Undefined: CHECKSUM is tied to 0 and no adder is built.

Test Plan:
- Load START_IDX=0, LEN=3, words 0x11,0x22,0x33, S_LAST on the 3rd -> imem[0..2] written, DONE after 3rd beat, ERR=0, CHECKSUM=0x66 (macro on).
- Load START_IDX=62, LEN=4 -> imem[62],imem[63],dmem[0],dmem[1] written; never both req high in one cycle.
- Unload START_IDX=64, LEN=5, M_READY toggling 1,0,0,1,... -> M_DATA = dmem[0..4] in order, no drop or duplicate, M_LAST only on 5th, DONE after 5th accept.
- START_IDX=190, LEN=3 -> ERR=1, DONE pulse next cycle, no RAM access; next valid START clears ERR.
- Load LEN=4 with S_LAST on 2nd beat -> 2 words written, ERR=1, DONE; LEN=0 -> DONE with no access.
- RST asserted mid-unload with buffer full -> M_VALID=0, BUSY=0, state IDLE the next cycle.
